// File: rtl/video_timing_rx.sv
// Receive-side video timing recovery: pixel coordinates, frame/line markers, timing measurement and lock.
// Optional measurement outputs are built only when VRX_MEAS_EN is defined; otherwise they are tied to 0.
module video_timing_rx #(
  parameter int H_DISP      = 3840,
  parameter int V_DISP      = 2160,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic        video_hs,
  input  logic        video_vs,
  input  logic        video_de,
  input  logic [23:0] video_rgb,
  output logic        pix_valid,
  output logic [23:0] pix_data,
  output logic [12:0] pix_x,
  output logic [12:0] pix_y,
  output logic        line_start,
  output logic        frame_start,
  output logic [12:0] meas_h_total,
  output logic [12:0] meas_h_act,
  output logic [12:0] meas_v_total,
  output logic [12:0] meas_v_act,
  output logic        meas_valid,
  output logic        locked
);

  localparam int CW = 13;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] H_DISP_C = CW'(H_DISP);
  localparam logic [CW-1:0] V_DISP_C = CW'(V_DISP);
  localparam logic [4:0]    LOCK_C   = 5'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  logic          r_s1_hs, r_s1_vs, r_s1_de;
  logic          r_s2_hs, r_s2_vs, r_s2_de;
  logic [23:0]   r_s1_rgb;

  logic          r_pix_valid;
  logic [23:0]   r_pix_data;
  logic [CW-1:0] r_pix_x;
  logic          r_line_start;
  logic          r_frame_start;

  logic [CW-1:0] r_h_cnt;
  logic [CW-1:0] r_v_cnt;
  logic [CW-1:0] r_y_cnt;
  logic          r_line_err;

  state_t        r_state, w_state_nx;
  logic [3:0]    r_good_cnt, w_good_nx;

  logic          w_hs_fall, w_vs_fall, w_de_rise, w_de_fall;
  logic [CW-1:0] w_run_len;
  logic          w_run_bad;
  logic [CW-1:0] w_y_inc;
  logic [CW-1:0] w_v_act_now;
  logic          w_frame_good;
  logic          w_lost;

  // Stage 1 samples the pins; stage 2 holds the previous sample for edge detection.
  // Syncs idle high so reset release does not fabricate an edge.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_s1_hs  <= 1'b1;
      r_s1_vs  <= 1'b1;
      r_s1_de  <= 1'b0;
      r_s1_rgb <= '0;
      r_s2_hs  <= 1'b1;
      r_s2_vs  <= 1'b1;
      r_s2_de  <= 1'b0;
    end else begin
      r_s1_hs  <= video_hs;
      r_s1_vs  <= video_vs;
      r_s1_de  <= video_de;
      r_s1_rgb <= video_rgb;
      r_s2_hs  <= r_s1_hs;
      r_s2_vs  <= r_s1_vs;
      r_s2_de  <= r_s1_de;
    end
  end

  assign w_hs_fall = r_s2_hs & ~r_s1_hs;
  assign w_vs_fall = r_s2_vs & ~r_s1_vs;
  assign w_de_rise = r_s1_de & ~r_s2_de;
  assign w_de_fall = r_s2_de & ~r_s1_de;

  // r_pix_x still holds the last column of the run when the fall is seen.
  assign w_run_len    = r_pix_x + 1'b1;
  assign w_run_bad    = w_de_fall && (w_run_len != H_DISP_C);
  assign w_y_inc      = (r_y_cnt == CNT_MAX) ? CNT_MAX : r_y_cnt + 1'b1;
  assign w_v_act_now  = w_de_fall ? w_y_inc : r_y_cnt;
  assign w_frame_good = (w_v_act_now == V_DISP_C) && !r_line_err && !w_run_bad && !r_s1_de;
  // A counter pinned at its ceiling means sync has disappeared; the edge that clears it does not count.
  assign w_lost       = ((r_h_cnt == CNT_MAX) && !w_hs_fall) ||
                        ((r_v_cnt == CNT_MAX) && !w_vs_fall);

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pix_valid   <= 1'b0;
      r_pix_data    <= '0;
      r_pix_x       <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_pix_valid   <= r_s1_de;
      r_pix_data    <= r_s1_de ? r_s1_rgb : 24'd0;
      r_line_start  <= w_de_rise;
      r_frame_start <= w_vs_fall;
      if (!r_s1_de)
        r_pix_x <= '0;
      else if (w_de_rise)
        r_pix_x <= '0;
      else
        r_pix_x <= r_pix_x + 1'b1;
    end
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_h_cnt    <= '0;
      r_v_cnt    <= '0;
      r_y_cnt    <= '0;
      r_line_err <= 1'b0;
    end else begin
      if (w_hs_fall)
        r_h_cnt <= '0;
      else if (r_h_cnt != CNT_MAX)
        r_h_cnt <= r_h_cnt + 1'b1;

      // An HS fall coincident with the VS fall is the first line of the new frame.
      if (w_vs_fall)
        r_v_cnt <= {{(CW-1){1'b0}}, w_hs_fall};
      else if (w_hs_fall && (r_v_cnt != CNT_MAX))
        r_v_cnt <= r_v_cnt + 1'b1;

      if (w_vs_fall)
        r_y_cnt <= '0;
      else if (w_de_fall)
        r_y_cnt <= w_y_inc;

      if (w_vs_fall)
        r_line_err <= 1'b0;
      else if (w_run_bad)
        r_line_err <= 1'b1;
    end
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= ST_SEARCH;
      r_good_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_good_cnt <= w_good_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_good_nx  = r_good_cnt;
    if (w_lost) begin
      w_state_nx = ST_SEARCH;
      w_good_nx  = '0;
    end else if (w_vs_fall) begin
      case (r_state)
        ST_SEARCH: begin
          w_state_nx = ST_MEASURE;
          w_good_nx  = '0;
        end
        ST_MEASURE: begin
          if (w_frame_good) begin
            w_good_nx = r_good_cnt + 1'b1;
            if (({1'b0, r_good_cnt} + 5'd1) >= LOCK_C)
              w_state_nx = ST_LOCKED;
          end else begin
            w_good_nx = '0;
          end
        end
        ST_LOCKED: begin
          if (!w_frame_good) begin
            w_state_nx = ST_MEASURE;
            w_good_nx  = '0;
          end
        end
        default: begin
          w_state_nx = ST_SEARCH;
          w_good_nx  = '0;
        end
      endcase
    end
  end

`ifdef VRX_MEAS_EN
  logic [CW-1:0] r_meas_h_total;
  logic [CW-1:0] r_meas_h_act;
  logic [CW-1:0] r_meas_v_total;
  logic [CW-1:0] r_meas_v_act;
  logic          r_meas_valid;

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_meas_h_total <= '0;
      r_meas_h_act   <= '0;
      r_meas_v_total <= '0;
      r_meas_v_act   <= '0;
      r_meas_valid   <= 1'b0;
    end else begin
      if (w_hs_fall)
        r_meas_h_total <= (r_h_cnt == CNT_MAX) ? CNT_MAX : r_h_cnt + 1'b1;
      if (w_de_fall)
        r_meas_h_act <= w_run_len;
      if (w_vs_fall) begin
        r_meas_v_total <= r_v_cnt;
        r_meas_v_act   <= w_v_act_now;
      end
      // Valid only after a frame bounded by two VS falls has been seen since SEARCH.
      if (w_lost)
        r_meas_valid <= 1'b0;
      else if (w_vs_fall && (r_state != ST_SEARCH))
        r_meas_valid <= 1'b1;
    end
  end

  assign meas_h_total = r_meas_h_total;
  assign meas_h_act   = r_meas_h_act;
  assign meas_v_total = r_meas_v_total;
  assign meas_v_act   = r_meas_v_act;
  assign meas_valid   = r_meas_valid;
`else
  assign meas_h_total = '0;
  assign meas_h_act   = '0;
  assign meas_v_total = '0;
  assign meas_v_act   = '0;
  assign meas_valid   = 1'b0;
`endif

  assign pix_valid   = r_pix_valid;
  assign pix_data    = r_pix_data;
  assign pix_x       = r_pix_x;
  assign pix_y       = r_y_cnt;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign locked      = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_video_timing_rx.sv
// Directed bench for video_timing_rx with a small 24x8 generator-style stream (16x4 active).
module tb_video_timing_rx;

  localparam int H_DISP = 16, V_DISP = 4, LOCK_FRAMES = 2;
  localparam int H_TOT = 24, V_TOT = 8, H_SYNC = 2, H_ACT0 = 5, V_SYNC = 1, V_ACT0 = 3;
  localparam int FRAME = H_TOT * V_TOT;

`ifdef VRX_MEAS_EN
  localparam bit MEAS = 1'b1;
`else
  localparam bit MEAS = 1'b0;
`endif

  logic        pixel_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        video_hs = 1'b1, video_vs = 1'b1, video_de = 1'b0;
  logic [23:0] video_rgb = '0;
  logic        pix_valid, line_start, frame_start, meas_valid, locked;
  logic [23:0] pix_data;
  logic [12:0] pix_x, pix_y, meas_h_total, meas_h_act, meas_v_total, meas_v_act;

  int errors = 0;
  int checks = 0;

  int g_h = 0, g_v = 0;
  bit g_short = 1'b0, g_idle = 1'b1;
  logic prev_vs = 1'b1, prev_de = 1'b0;

  logic        e_de [0:2];
  logic [23:0] e_rgb[0:2];
  logic [12:0] e_x  [0:2];
  logic [12:0] e_y  [0:2];
  logic        e_ls [0:2];
  logic        e_fs [0:2];

  video_timing_rx #(.H_DISP(H_DISP), .V_DISP(V_DISP), .LOCK_FRAMES(LOCK_FRAMES)) dut (
    .pixel_clk(pixel_clk), .sys_rst_n(sys_rst_n),
    .video_hs(video_hs), .video_vs(video_vs), .video_de(video_de), .video_rgb(video_rgb),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .line_start(line_start), .frame_start(frame_start),
    .meas_h_total(meas_h_total), .meas_h_act(meas_h_act),
    .meas_v_total(meas_v_total), .meas_v_act(meas_v_act),
    .meas_valid(meas_valid), .locked(locked)
  );

  always #5 pixel_clk = ~pixel_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  // One pixel clock of stimulus, driven on the falling edge; outputs seen afterwards reflect the cycle two steps back.
  task automatic step();
    logic hs, vs, de;
    logic [23:0] rgb;
    int ae;
    @(negedge pixel_clk);
    if (g_idle) begin
      hs = 1'b1; vs = 1'b1; de = 1'b0;
    end else begin
      hs = (g_h >= H_SYNC);
      vs = (g_v >= V_SYNC);
      ae = (g_short && g_v == V_ACT0 + V_DISP - 1) ? H_ACT0 + H_DISP - 1 : H_ACT0 + H_DISP;
      de = (g_v >= V_ACT0) && (g_v < V_ACT0 + V_DISP) && (g_h >= H_ACT0) && (g_h < ae);
    end
    rgb = de ? {12'(g_v - V_ACT0), 12'(g_h - H_ACT0)} : 24'hABCDEF;
    video_hs = hs; video_vs = vs; video_de = de; video_rgb = rgb;
    for (int i = 2; i > 0; i--) begin
      e_de[i] = e_de[i-1]; e_rgb[i] = e_rgb[i-1]; e_x[i] = e_x[i-1];
      e_y[i] = e_y[i-1]; e_ls[i] = e_ls[i-1]; e_fs[i] = e_fs[i-1];
    end
    e_de[0]  = de;
    e_rgb[0] = de ? rgb : 24'd0;
    e_x[0]   = de ? 13'(g_h - H_ACT0) : 13'd0;
    e_y[0]   = 13'(g_v - V_ACT0);
    e_ls[0]  = de & ~prev_de;
    e_fs[0]  = ~vs & prev_vs;
    prev_de  = de;
    prev_vs  = vs;
    if (!g_idle) begin
      g_h++;
      if (g_h == H_TOT) begin
        g_h = 0;
        g_v++;
        if (g_v == V_TOT) begin
          g_v = 0;
          g_short = 1'b0;
        end
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    g_idle = 1'b1;
    steps(3);
    checks++;
    if ({pix_valid, pix_data, pix_x, pix_y, line_start, frame_start, meas_h_total, meas_h_act,
         meas_v_total, meas_v_act, meas_valid, locked} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero output vector pix_data=%h pix_x=%0d locked=%b exp all 0",
               pix_data, pix_x, locked);
    end
    sys_rst_n = 1'b1;
    steps(4);
    checks++;
    if ({frame_start, locked, pix_valid, meas_valid} !== 4'b0) begin
      errors++;
      $display("FAIL post_reset_idle: fs=%b locked=%b valid=%b mv=%b exp 0", frame_start, locked, pix_valid, meas_valid);
    end
    g_idle = 1'b0; g_h = 0; g_v = 0;
  endtask

  task automatic test_lock_measure();
    steps(3);
    checks++;
    if (frame_start !== 1'b1) begin errors++; $display("FAIL vsf1_frame_start: got %b exp 1", frame_start); end
    checks++;
    if ({locked, meas_valid} !== 2'b00) begin errors++; $display("FAIL vsf1_lock_mv: got %b%b exp 00", locked, meas_valid); end
    steps(FRAME);
    checks++;
    if (meas_valid !== MEAS) begin errors++; $display("FAIL vsf2_meas_valid: got %b exp %b", meas_valid, MEAS); end
    checks++;
    if (meas_h_total !== (MEAS ? 13'd24 : 13'd0)) begin errors++; $display("FAIL meas_h_total: got %0d exp %0d", meas_h_total, MEAS ? 24 : 0); end
    checks++;
    if (meas_h_act !== (MEAS ? 13'd16 : 13'd0)) begin errors++; $display("FAIL meas_h_act: got %0d exp %0d", meas_h_act, MEAS ? 16 : 0); end
    checks++;
    if (meas_v_total !== (MEAS ? 13'd8 : 13'd0)) begin errors++; $display("FAIL meas_v_total: got %0d exp %0d", meas_v_total, MEAS ? 8 : 0); end
    checks++;
    if (meas_v_act !== (MEAS ? 13'd4 : 13'd0)) begin errors++; $display("FAIL meas_v_act: got %0d exp %0d", meas_v_act, MEAS ? 4 : 0); end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL vsf2_locked: got %b exp 0", locked); end
    steps(FRAME);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL vsf3_locked: got %b exp 1", locked); end
    steps(1);
    checks++;
    if (frame_start !== 1'b0) begin errors++; $display("FAIL frame_start_width: got %b exp 0", frame_start); end
  endtask

  task automatic test_pixels();
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++;
      if (pix_valid !== e_de[2]) begin errors++; $display("FAIL pix_valid[%0d]: got %b exp %b", i, pix_valid, e_de[2]); end
      checks++;
      if (pix_data !== e_rgb[2]) begin errors++; $display("FAIL pix_data[%0d]: got %h exp %h", i, pix_data, e_rgb[2]); end
      checks++;
      if (pix_x !== e_x[2]) begin errors++; $display("FAIL pix_x[%0d]: got %0d exp %0d", i, pix_x, e_x[2]); end
      checks++;
      if (line_start !== e_ls[2]) begin errors++; $display("FAIL line_start[%0d]: got %b exp %b", i, line_start, e_ls[2]); end
      checks++;
      if (frame_start !== e_fs[2]) begin errors++; $display("FAIL frame_start[%0d]: got %b exp %b", i, frame_start, e_fs[2]); end
      if (e_de[2]) begin
        checks++;
        if (pix_y !== e_y[2]) begin errors++; $display("FAIL pix_y[%0d]: got %0d exp %0d", i, pix_y, e_y[2]); end
      end
    end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL pixels_locked: got %b exp 1", locked); end
  endtask

  task automatic test_short_line();
    g_short = 1'b1;
    steps(FRAME - 4 + 2);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL short_pre_locked: got %b exp 1", locked); end
    checks++;
    if (meas_h_act !== (MEAS ? 13'd15 : 13'd0)) begin errors++; $display("FAIL short_pre_h_act: got %0d exp %0d", meas_h_act, MEAS ? 15 : 0); end
    steps(1);
    checks++;
    if ({frame_start, locked} !== 2'b10) begin errors++; $display("FAIL short_vsf: fs=%b locked=%b exp fs=1 locked=0", frame_start, locked); end
    checks++;
    if (meas_h_act !== (MEAS ? 13'd15 : 13'd0)) begin errors++; $display("FAIL short_h_act: got %0d exp %0d", meas_h_act, MEAS ? 15 : 0); end
    steps(FRAME);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL short_relock1: got %b exp 0", locked); end
    steps(FRAME);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL short_relock2: got %b exp 1", locked); end
  endtask

  task automatic test_lost_sync();
    g_idle = 1'b1;
    steps(4000);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL idle_early_locked: got %b exp 1", locked); end
    steps(4300);
    checks++;
    if ({locked, meas_valid} !== 2'b00) begin errors++; $display("FAIL lost_sync: locked=%b mv=%b exp 00", locked, meas_valid); end
    g_idle = 1'b0; g_h = 0; g_v = 0; g_short = 1'b0;
    steps(3);
    checks++;
    if ({frame_start, locked, meas_valid} !== 3'b100) begin
      errors++; $display("FAIL resume_vsf1: fs=%b locked=%b mv=%b exp 100", frame_start, locked, meas_valid);
    end
    steps(FRAME);
    checks++;
    if ({locked, meas_valid} !== {1'b0, MEAS}) begin errors++; $display("FAIL resume_vsf2: locked=%b mv=%b exp 0%b", locked, meas_valid, MEAS); end
    steps(FRAME);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL resume_vsf3_locked: got %b exp 1", locked); end
  endtask

  task automatic test_reset_mid();
    bit saw_fs;
    steps(100);
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({pix_valid, pix_data, pix_x, pix_y, line_start, frame_start, meas_h_total, meas_h_act,
         meas_v_total, meas_v_act, meas_valid, locked} !== '0) begin
      errors++; $display("FAIL midreset_async: pix_valid=%b pix_x=%0d locked=%b exp all 0", pix_valid, pix_x, locked);
    end
    steps(3);
    checks++;
    if ({pix_valid, pix_data, locked, meas_valid} !== '0) begin
      errors++; $display("FAIL midreset_hold: valid=%b data=%h locked=%b exp 0", pix_valid, pix_data, locked);
    end
    sys_rst_n = 1'b1;
    saw_fs = 1'b0;
    for (int i = 0; i < 88; i++) begin
      step();
      if (frame_start) saw_fs = 1'b1;
    end
    checks++;
    if (saw_fs !== 1'b0) begin errors++; $display("FAIL midreset_false_fs: got 1 exp 0"); end
    steps(1);
    checks++;
    if ({frame_start, locked, meas_valid} !== 3'b100) begin
      errors++; $display("FAIL midreset_vsf1: fs=%b locked=%b mv=%b exp 100", frame_start, locked, meas_valid);
    end
    steps(FRAME);
    checks++;
    if ({locked, meas_valid} !== {1'b0, MEAS}) begin errors++; $display("FAIL midreset_vsf2: locked=%b mv=%b exp 0%b", locked, meas_valid, MEAS); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      e_de[i] = 1'b0; e_rgb[i] = '0; e_x[i] = '0; e_y[i] = '0; e_ls[i] = 1'b0; e_fs[i] = 1'b0;
    end
    test_reset();
    test_lock_measure();
    test_pixels();
    test_short_line();
    test_lost_sync();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
